// File: rtl/mem_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the two masters and the slave
// side of mem_rd_arbiter.
interface mem_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arsize, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arsize, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter. One read in flight at a time; the owner keeps
// the port from AR grant until its rlast beat is accepted.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter bit          LSU_PRIO = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  mem_rd_arbiter_if.slave  m0,
  mem_rd_arbiter_if.slave  m1,
  mem_rd_arbiter_if.master s,
  output logic             busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr0  = 3'd1;
  localparam logic [2:0] StAr1  = 3'd2;
  localparam logic [2:0] StR0   = 3'd3;
  localparam logic [2:0] StR1   = 3'd4;

  logic [2:0] state_q, state_d;
  // 1 means M1 was granted last; reset value lets M0 win the first round-robin tie.
  logic       last_grant_q, last_grant_d;

  logic              in_ar, in_r, own_m1;
  logic              own_arvalid, own_rready;
  logic [ADDR_W-1:0] own_araddr;
  logic [2:0]        own_arsize;
  logic [7:0]        own_arlen;
  logic              ar_hs, r_done;
  logic              pick_m1;
  logic [DATA_W-1:0] r_data;

  assign in_ar  = (state_q == StAr0) || (state_q == StAr1);
  assign in_r   = (state_q == StR0) || (state_q == StR1);
  assign own_m1 = (state_q == StAr1) || (state_q == StR1);

  assign own_arvalid = own_m1 ? m1.arvalid : m0.arvalid;
  assign own_araddr  = own_m1 ? m1.araddr  : m0.araddr;
  assign own_arsize  = own_m1 ? m1.arsize  : m0.arsize;
  assign own_arlen   = own_m1 ? m1.arlen   : m0.arlen;
  assign own_rready  = own_m1 ? m1.rready  : m0.rready;

  assign ar_hs  = in_ar && own_arvalid && s.arready;
  assign r_done = in_r && s.rvalid && own_rready && s.rlast;

  // Tie-break when both request in IDLE.
  assign pick_m1 = LSU_PRIO || !last_grant_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (m0.arvalid && m1.arvalid) begin
          state_d = pick_m1 ? StAr1 : StAr0;
        end else if (m0.arvalid) begin
          state_d = StAr0;
        end else if (m1.arvalid) begin
          state_d = StAr1;
        end
      end
      StAr0: begin
        if (ar_hs) begin
          state_d      = StR0;
          last_grant_d = 1'b0;
        end
      end
      StAr1: begin
        if (ar_hs) begin
          state_d      = StR1;
          last_grant_d = 1'b1;
        end
      end
      StR0, StR1: begin
        if (r_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s.arvalid = in_ar && own_arvalid;
  assign s.araddr  = in_ar ? own_araddr : '0;
  assign s.arsize  = in_ar ? own_arsize : '0;
  assign s.arlen   = in_ar ? own_arlen  : '0;
  assign s.rready  = in_r && own_rready;

  assign m0.arready = in_ar && !own_m1 && s.arready;
  assign m1.arready = in_ar && own_m1 && s.arready;
  assign m0.rvalid  = in_r && !own_m1 && s.rvalid;
  assign m1.rvalid  = in_r && own_m1 && s.rvalid;

  // R payload is broadcast; only the owner's rvalid qualifies it.
  assign r_data   = s.rdata;
  assign m0.rdata = r_data;
  assign m1.rdata = r_data;
  assign m0.rresp = s.rresp;
  assign m1.rresp = s.rresp;
  assign m0.rlast = s.rlast;
  assign m1.rlast = s.rlast;

  assign busy = (state_q != StIdle);

`ifndef SYNTHESIS
  a_rvalid_excl: assert property (@(posedge clock) disable iff (reset)
    !(m0.rvalid && m1.rvalid));
  a_arready_excl: assert property (@(posedge clock) disable iff (reset)
    !(m0.arready && m1.arready));
  a_state_legal: assert property (@(posedge clock) disable iff (reset)
    state_q <= StR1);
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench: a priority instance with a gap-capable slave model, plus a round-robin
// instance with a simple slave and free-running requesters.
module tb_mem_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- LSU_PRIO=1 instance ----------------
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  logic busy;

  mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b1)) u_dut (
    .clock (clk),
    .reset (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .busy  (busy)
  );

  logic m0_rready_en, stall_en, sl_gap_en;
  logic [1:0] sl_resp;
  assign m0_if.rready = m0_rready_en && !(stall_en && cyc[1]);
  assign m1_if.rready = 1'b1;

  // Slave model: data = araddr + beat index, optional rvalid gaps.
  logic sl_busy, sl_rvalid;
  logic [31:0] sl_addr;
  logic [7:0] sl_len, sl_beat;
  assign s_if.arready = !sl_busy;
  assign s_if.rvalid  = sl_rvalid;
  assign s_if.rdata   = sl_addr + 32'(sl_beat);
  assign s_if.rresp   = sl_resp;
  assign s_if.rlast   = (sl_beat == sl_len);

  always @(posedge clk) begin
    if (rst) begin
      sl_busy <= 1'b0; sl_rvalid <= 1'b0; sl_addr <= '0; sl_len <= '0; sl_beat <= '0;
    end else if (!sl_busy) begin
      if (s_if.arvalid) begin
        sl_busy <= 1'b1; sl_addr <= s_if.araddr; sl_len <= s_if.arlen; sl_beat <= '0;
      end
    end else if (sl_rvalid) begin
      if (s_if.rready) begin
        if (sl_beat == sl_len) begin
          sl_busy <= 1'b0; sl_rvalid <= 1'b0;
        end else begin
          sl_beat   <= sl_beat + 8'd1;
          sl_rvalid <= !(sl_gap_en && cyc[0]);
        end
      end
    end else begin
      sl_rvalid <= !(sl_gap_en && cyc[0]);
    end
  end

  // Monitor
  logic [31:0] r0_data_q[$], r1_data_q[$], ar_addr_q[$];
  logic [1:0]  r1_resp_q[$];
  int          ar_cyc_q[$], rlast_cyc_q[$];
  logic        busy_after_q[$];
  int          m1_rv_cnt = 0;
  logic        prev_arv = 1'b0, prev_hs = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (m0_if.rvalid && m0_if.rready) r0_data_q.push_back(m0_if.rdata);
      if (m1_if.rvalid && m1_if.rready) begin
        r1_data_q.push_back(m1_if.rdata);
        r1_resp_q.push_back(m1_if.rresp);
      end
      if (s_if.arvalid && s_if.arready) ar_addr_q.push_back(s_if.araddr);
      if (s_if.arvalid && !prev_arv) ar_cyc_q.push_back(cyc);
      if (s_if.rvalid && s_if.rready && s_if.rlast) rlast_cyc_q.push_back(cyc);
      if (prev_hs) busy_after_q.push_back(busy);
      if (m1_if.rvalid) m1_rv_cnt <= m1_rv_cnt + 1;
    end
    prev_arv <= s_if.arvalid;
    prev_hs  <= m0_if.rvalid && m0_if.rready;
  end

  wire [6:0] outs = {busy, s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready,
                     m0_if.rvalid, m1_if.rvalid};

  // ---------------- LSU_PRIO=0 instance ----------------
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) rm0_if ();
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) rm1_if ();
  mem_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) rs_if ();
  logic rr_busy, rr_en;

  mem_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1'b0)) u_dut_rr (
    .clock (clk),
    .reset (rst),
    .m0    (rm0_if),
    .m1    (rm1_if),
    .s     (rs_if),
    .busy  (rr_busy)
  );

  logic [1:0] rr_cnt0, rr_cnt1;
  assign rm0_if.arvalid = rr_en && (rr_cnt0 < 2'd3);
  assign rm0_if.araddr  = 32'hA000_0000 + 32'(rr_cnt0);
  assign rm0_if.arsize  = 3'd2;
  assign rm0_if.arlen   = 8'd0;
  assign rm0_if.rready  = 1'b1;
  assign rm1_if.arvalid = rr_en && (rr_cnt1 < 2'd3);
  assign rm1_if.araddr  = 32'hB000_0000 + 32'(rr_cnt1);
  assign rm1_if.arsize  = 3'd2;
  assign rm1_if.arlen   = 8'd0;
  assign rm1_if.rready  = 1'b1;

  logic rsl_busy;
  logic [31:0] rsl_addr;
  assign rs_if.arready = !rsl_busy;
  assign rs_if.rvalid  = rsl_busy;
  assign rs_if.rdata   = rsl_addr;
  assign rs_if.rresp   = 2'b00;
  assign rs_if.rlast   = 1'b1;

  logic [31:0] rr_log_q[$];
  always @(posedge clk) begin
    if (rst) begin
      rsl_busy <= 1'b0; rsl_addr <= '0; rr_cnt0 <= '0; rr_cnt1 <= '0;
    end else begin
      if (!rsl_busy) begin
        if (rs_if.arvalid) begin
          rsl_busy <= 1'b1; rsl_addr <= rs_if.araddr;
        end
      end else if (rs_if.rready) begin
        rsl_busy <= 1'b0;
      end
      if (rm0_if.arvalid && rm0_if.arready) rr_cnt0 <= rr_cnt0 + 2'd1;
      if (rm1_if.arvalid && rm1_if.arready) rr_cnt1 <= rr_cnt1 + 2'd1;
      if (rs_if.arvalid && rs_if.arready) rr_log_q.push_back(rs_if.araddr);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic ar_drive(input int m, input logic [31:0] addr, input logic [7:0] len);
    if (m == 0) begin
      m0_if.arvalid = 1'b1; m0_if.araddr = addr; m0_if.arlen = len; m0_if.arsize = 3'd2;
    end else begin
      m1_if.arvalid = 1'b1; m1_if.araddr = addr; m1_if.arlen = len; m1_if.arsize = 3'd2;
    end
  endtask

  // Waits for the AR grant, then drops arvalid after the accepting edge.
  task automatic wait_arready(input int m);
    int k = 0;
    while (((m == 0) ? m0_if.arready : m1_if.arready) !== 1'b1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("ar_accept_in_time", 64'(k < 100), 64'd1);
    @(posedge clk); #1;
    if (m == 0) m0_if.arvalid = 1'b0;
    else m1_if.arvalid = 1'b0;
  endtask

  task automatic wait_beats(input int m, input int n);
    int k = 0;
    while (((m == 0) ? r0_data_q.size() : r1_data_q.size()) < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("beat_count", 64'((m == 0) ? r0_data_q.size() : r1_data_q.size()), 64'(n));
  endtask

  int n0, n1, na, nc, nl, nb, m1c;
  int k;

  initial begin
    rst = 1'b1;
    m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.arsize = '0; m0_if.arlen = '0;
    m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.arsize = '0; m1_if.arlen = '0;
    m0_rready_en = 1'b1; stall_en = 1'b0; sl_gap_en = 1'b0; sl_resp = 2'b00; rr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", 64'(outs), 64'd0);
    check_eq("reset_araddr", 64'(s_if.araddr), 64'd0);
    rst = 1'b0;
    rr_en = 1'b1;
    @(posedge clk); #1;

    // Single M0 read, len=0: one arbitration cycle, then AR, then one beat.
    n0 = r0_data_q.size();
    ar_drive(0, 32'h3000_0000, 8'd0);
    #1;
    check_eq("t1_no_arvalid_in_idle", 64'(s_if.arvalid), 64'd0);
    check_eq("t1_busy_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_eq("t1_arvalid_t1", 64'(s_if.arvalid), 64'd1);
    check_eq("t1_araddr", 64'(s_if.araddr), 64'h3000_0000);
    check_eq("t1_arready_m0m1", 64'({m0_if.arready, m1_if.arready}), 64'b10);
    check_eq("t1_busy_ar", 64'(busy), 64'd1);
    wait_arready(0);
    wait_beats(0, n0 + 1);
    check_eq("t1_rdata", 64'(r0_data_q[n0]), 64'h3000_0000);
    check_eq("t1_idle_after_rlast", 64'(busy), 64'd0);

    // Simultaneous requests with LSU priority: M1 first, M0 AR two cycles after M1 rlast.
    @(posedge clk); #1;
    n0 = r0_data_q.size(); n1 = r1_data_q.size();
    na = ar_addr_q.size(); nc = ar_cyc_q.size(); nl = rlast_cyc_q.size();
    ar_drive(0, 32'h3000_0100, 8'd0);
    ar_drive(1, 32'h2000_0200, 8'd1);
    @(posedge clk); #1;
    check_eq("t2_m1_first_addr", 64'(s_if.araddr), 64'h2000_0200);
    check_eq("t2_arready_m0m1", 64'({m0_if.arready, m1_if.arready}), 64'b01);
    wait_arready(1);
    wait_arready(0);
    wait_beats(0, n0 + 1);
    wait_beats(1, n1 + 2);
    check_eq("t2_ar_order0", 64'(ar_addr_q[na]), 64'h2000_0200);
    check_eq("t2_ar_order1", 64'(ar_addr_q[na + 1]), 64'h3000_0100);
    check_eq("t2_m1_beat0", 64'(r1_data_q[n1]), 64'h2000_0200);
    check_eq("t2_m1_beat1", 64'(r1_data_q[n1 + 1]), 64'h2000_0201);
    check_eq("t2_m0_beat", 64'(r0_data_q[n0]), 64'h3000_0100);
    check_eq("t2_ar_gap_after_rlast", 64'(ar_cyc_q[nc + 1] - rlast_cyc_q[nl]), 64'd2);

    // M0 burst of 4 with slave gaps and master stalls.
    @(posedge clk); #1;
    n0 = r0_data_q.size(); nb = busy_after_q.size(); m1c = m1_rv_cnt;
    stall_en = 1'b1; sl_gap_en = 1'b1;
    ar_drive(0, 32'h1000_0040, 8'd3);
    wait_arready(0);
    wait_beats(0, n0 + 4);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_beat_data", 64'(r0_data_q[n0 + i]), 64'h1000_0040 + 64'(i));
      check_eq("t4_busy_after_beat", 64'(busy_after_q[nb + i]), 64'(i < 3));
    end
    check_eq("t4_m1_rvalid_quiet", 64'(m1_rv_cnt - m1c), 64'd0);
    stall_en = 1'b0; sl_gap_en = 1'b0;

    // SLVERR to M1 passes through unchanged.
    @(posedge clk); #1;
    n1 = r1_data_q.size();
    sl_resp = 2'b10;
    ar_drive(1, 32'h2000_0300, 8'd0);
    wait_arready(1);
    wait_beats(1, n1 + 1);
    check_eq("t5_rresp", 64'(r1_resp_q[n1]), 64'h2);
    check_eq("t5_idle_after_err", 64'(busy), 64'd0);
    sl_resp = 2'b00;

    // Round-robin instance: alternating grants starting with M0.
    k = 0;
    while (rr_log_q.size() < 6 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("t3_rr_count", 64'(rr_log_q.size()), 64'd6);
    if (rr_log_q.size() >= 4) begin
      check_eq("t3_rr_grant0", 64'(rr_log_q[0]), 64'hA000_0000);
      check_eq("t3_rr_grant1", 64'(rr_log_q[1]), 64'hB000_0000);
      check_eq("t3_rr_grant2", 64'(rr_log_q[2]), 64'hA000_0001);
      check_eq("t3_rr_grant3", 64'(rr_log_q[3]), 64'hB000_0001);
    end
    rr_en = 1'b0;

    // Reset mid-burst in R0 drops everything at once.
    n0 = r0_data_q.size();
    ar_drive(0, 32'h3000_0400, 8'd7);
    wait_arready(0);
    wait_beats(0, n0 + 2);
    check_eq("t6_busy_in_burst", 64'(busy), 64'd1);
    check_eq("t6_beat1", 64'(r0_data_q[n0 + 1]), 64'h3000_0401);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_reset_outputs", 64'(outs), 64'd0);
    check_eq("t6_reset_araddr", 64'(s_if.araddr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    n1 = r1_data_q.size();
    ar_drive(1, 32'h2000_0500, 8'd0);
    wait_arready(1);
    wait_beats(1, n1 + 1);
    check_eq("t6_recovery_data", 64'(r1_data_q[n1]), 64'h2000_0500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
